uart_tx_frame_gen: RTL and testbench
====================================

// Module: uart_tx_frame_gen
// PURPOSE
//  Parametrised UART transmit framer: latches a parallel word plus frame config, then shifts out
//  start bit, DATA_WIDTH data bits (LSB first), optional parity bit and 1 or 2 stop bits on a
//  registered serial line. Built-in bit-period prescaler, so it can run on a fast clock or,
//  with BAUD_DIV=1, directly on the baud clock. Next-generation replacement for the UART_TX
//  select/output stage; sits between the TX data source and the pad.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame; legal range 5..9
//  BAUD_DIV    1  CLK cycles per serial bit; legal >=1; BAUD_DIV=1 gives one bit per clock
// PORTS
//  CLK         in   1           single clock; all state updates on rising edge
//  RST         in   1           asynchronous, active-high reset
//  P_DATA      in   DATA_WIDTH  parallel word to send
//  Data_Valid  in   1           request; accepted only when Busy=0
//  PAR_EN      in   1           1 = insert parity bit
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  STOP2       in   1           1 = two stop bits, 0 = one
//  TX_OUT      out  1           serial line, registered, idle high
//  Busy        out  1           high from acceptance until end of the last stop bit
// BEHAVIOUR
//  - Reset (async): TX_OUT=1, Busy=0, state=IDLE, bit/prescaler counters=0, latched regs=0.
//  - FSM: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> (STOP again if STOP2) -> IDLE.
//  - Accept: rising edge with Data_Valid=1 and Busy=0 latches P_DATA, PAR_EN, PAR_TYP, STOP2;
//    at that same edge TX_OUT<=0 (start), Busy<=1. Latency request->start bit = 1 clock.
//  - Each bit held exactly BAUD_DIV clocks; prescaler counts 0..BAUD_DIV-1, bit advances on wrap.
//  - DATA: bit i (i=0..DATA_WIDTH-1) = latched data[i]; bit counter wraps at DATA_WIDTH-1.
//  - Parity: even = ^data, odd = ~^data, computed on latched data.
//  - STOP: TX_OUT=1; at the edge ending the final stop bit, state<=IDLE, Busy<=0, TX_OUT stays 1.
//  - Frame length = (1+DATA_WIDTH+PAR_EN+1+STOP2)*BAUD_DIV clocks of Busy=1.
//  - Back-to-back: Data_Valid held high re-accepts on the first edge with Busy=0, so the
//    minimum gap between frames is one CLK of idle (line high).
//  - Data_Valid while Busy=1: ignored, not queued. P_DATA/config changes mid-frame: no effect.
//  - RST asserted mid-frame: TX_OUT forced 1 and Busy 0 immediately; frame is abandoned.
//  - No combinational path from any input to TX_OUT.
// CONFIGURATION
//  UART_TX_FRAME_BREAK_EN defined: extra input Break_Req (1 bit). In IDLE with Break_Req=1,
//   FSM enters BREAK: TX_OUT=0, Busy=1, Data_Valid ignored. On Break_Req=0, FSM enters MARK:
//   TX_OUT=1 for one bit period (BAUD_DIV clocks), Busy=1, then IDLE. Break_Req during a frame
//   is ignored until IDLE. Reset forces IDLE from BREAK/MARK.
//  Not defined: no Break_Req port, no BREAK/MARK states; behaviour as above.
// TESTING
//  1 DW=8,DIV=1: P_DATA=8'hA5,PAR_EN=1,PAR_TYP=0,STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1;
//    Busy high 11 clks.
//  2 DW=8,DIV=1: P_DATA=8'h01,PAR_EN=1,PAR_TYP=1 -> parity bit 0; P_DATA=8'h03 -> parity bit 1.
//  3 DW=8,DIV=4: P_DATA=8'hFF,PAR_EN=0,STOP2=1 -> start low 4 clks, 10 high bits (40 clks);
//    Busy high 44 clks.
//  4 Pulse Data_Valid with P_DATA=8'h00 during frame of 8'h55 -> 8'h55 frame unchanged,
//    no second frame.
//  5 Data_Valid held high, DIV=1, 8'hA5 no parity -> frames separated by exactly 1 idle clk.
//  6 RST pulse at data bit 3 -> TX_OUT=1, Busy=0 before next edge; next request sends a full
//    clean frame. With UART_TX_FRAME_BREAK_EN: Break_Req high 20 clks -> TX_OUT low 20 clks,
//    then high, Busy low after DIV clks.

Source files
------------

// File: rtl/uart_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_gen
//
// Parametrised UART transmit framer. A request (Data_Valid while Busy=0)
// latches the parallel word and the frame configuration. The framer then
// shifts out a start bit, DATA_WIDTH data bits (LSB first), an optional
// parity bit and one or two stop bits on a registered serial line. Every
// serial bit is held for BAUD_DIV clocks, so the block runs either on a fast
// system clock or, with BAUD_DIV=1, directly on the baud clock.
//
// Optional feature (compile-time macro UART_TX_FRAME_BREAK_EN):
//   adds input Break_Req. From IDLE, Break_Req=1 holds the line low (BREAK)
//   for as long as it stays high. After it drops, one bit period of mark
//   (line high, still Busy) is sent before returning to IDLE. Without the
//   macro the port and the BREAK/MARK states do not exist.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   BAUD_DIV    clocks per serial bit (>=1)
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous reset, active high
//   P_DATA      parallel word to send
//   Data_Valid  send request, taken only while Busy=0
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   STOP2       1 = two stop bits, 0 = one stop bit
//   Break_Req   (UART_TX_FRAME_BREAK_EN only) line break request
//   TX_OUT      registered serial line, idles high
//   Busy        high from acceptance until the end of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
`ifdef UART_TX_FRAME_BREAK_EN
    input  logic                  Break_Req,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);

    // A 1-bit prescaler is kept even for BAUD_DIV=1; it simply stays at 0
    // and every clock is a bit boundary.
    localparam int PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [PW-1:0] PRE_LAST = PW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_FRAME_BREAK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`endif

    state_t                  state_q,   state_d;
    logic [PW-1:0]           pre_q,     pre_d;
    logic [BW-1:0]           bit_q,     bit_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic                    par_en_q,  par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    stop2_q,   stop2_d;
    logic                    tx_q,      tx_d;
    logic                    busy_q,    busy_d;

    logic                    bit_tick;

    // Last clock of the current bit period.
    assign bit_tick = (pre_q == PRE_LAST);

    // -----------------------------------------------------------------------
    // State register (all sequential state)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pre_d     = bit_tick ? '0 : pre_q + PW'(1);
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;

        case (state_q)
            S_IDLE: begin
                // Prescaler and bit counter parked so every bit period of
                // the next frame starts aligned to the accepting edge.
                pre_d = '0;
                bit_d = '0;
`ifdef UART_TX_FRAME_BREAK_EN
                if (Break_Req) begin
                    state_d = S_BREAK;
                end else
`endif
                if (Data_Valid) begin
                    state_d   = S_START;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                end
            end

            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end

            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end

            S_STOP: begin
                // bit_q counts stop bits sent so far (0 or 1).
                if (bit_tick) begin
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BW'(1);
                    end else begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end

`ifdef UART_TX_FRAME_BREAK_EN
            S_BREAK: begin
                // Prescaler held at 0 so the following mark lasts exactly
                // one full bit period.
                pre_d = '0;
                if (!Break_Req) begin
                    state_d = S_MARK;
                end
            end

            S_MARK: begin
                if (bit_tick) begin
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: decoded from the next state so TX_OUT/Busy change on the
    // same edge as the state and are driven straight from flops.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d != S_IDLE);
        tx_d   = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[bit_d];
            S_PARITY: tx_d = par_typ_q ? ~^data_q : ^data_q;
`ifdef UART_TX_FRAME_BREAK_EN
            S_BREAK:  tx_d = 1'b0;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame_gen
//
// Two framers share clock and reset: index 0 runs with BAUD_DIV=1, index 1
// with BAUD_DIV=4. A table of frames with hand-derived serial sequences is
// replayed, followed by hand-written sequences for the multi-cycle corners
// (mid-frame request, back-to-back, mid-frame reset, optional line break).
// ---------------------------------------------------------------------------
module tb_uart_tx_frame_gen;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic            RST = 1'b0;
    logic [1:0][7:0] pd  = '0;
    logic [1:0]      dv  = '0;
    logic [1:0]      pe  = '0;
    logic [1:0]      pt  = '0;
    logic [1:0]      s2  = '0;
    wire  [1:0]      tx;
    wire  [1:0]      bsy;
`ifdef UART_TX_FRAME_BREAK_EN
    logic [1:0]      brk = '0;
`endif

    uart_tx_frame_gen #(.DATA_WIDTH(8), .BAUD_DIV(1)) u_div1 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[0]), .Data_Valid(dv[0]),
        .PAR_EN(pe[0]), .PAR_TYP(pt[0]), .STOP2(s2[0]),
`ifdef UART_TX_FRAME_BREAK_EN
        .Break_Req(brk[0]),
`endif
        .TX_OUT(tx[0]), .Busy(bsy[0])
    );

    uart_tx_frame_gen #(.DATA_WIDTH(8), .BAUD_DIV(4)) u_div4 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[1]), .Data_Valid(dv[1]),
        .PAR_EN(pe[1]), .PAR_TYP(pt[1]), .STOP2(s2[1]),
`ifdef UART_TX_FRAME_BREAK_EN
        .Break_Req(brk[1]),
`endif
        .TX_OUT(tx[1]), .Busy(bsy[1])
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Serial bits are written left to right in transmit order.
    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        s2;
        int          nbits;
        logic [0:15] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic int div_of(input int sel);
        return (sel == 0) ? 1 : 4;
    endfunction

    // Present a request so it is taken at the next rising edge; returns just
    // after that edge.
    task automatic start(input int sel, input logic [7:0] d, input logic p_e,
                         input logic p_t, input logic s_2);
        @(negedge CLK);
        pd[sel] = d; pe[sel] = p_e; pt[sel] = p_t; s2[sel] = s_2; dv[sel] = 1'b1;
        @(posedge CLK);
    endtask

    // Called right after the accepting edge. Samples at each falling edge
    // until Busy drops (returning at that idle sample) or the budget runs out.
    task automatic capture(input int sel, input bit keep_dv, input int inj_at,
                           output logic [0:15] bits, output int nbusy, output bit stable);
        int div;
        div    = div_of(sel);
        bits   = '0;
        nbusy  = 0;
        stable = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (c == 0 && !keep_dv) dv[sel] = 1'b0;
            if (inj_at >= 0 && c == inj_at) begin
                pd[sel] = 8'h00; dv[sel] = 1'b1;
            end else if (inj_at >= 0 && c == inj_at + 1) begin
                dv[sel] = 1'b0;
            end
            if (!bsy[sel]) break;
            nbusy++;
            if (c / div < 16) begin
                if (c % div == 0) bits[c / div] = tx[sel];
                else if (tx[sel] !== bits[c / div]) stable = 1'b0;
            end
            @(posedge CLK);
        end
    endtask

    task automatic check_frame(input string tag, input int sel, input logic [0:15] bits,
                               input int nbusy, input bit stable,
                               input logic [0:15] exp, input int nbits);
        chk({tag, " bits"},   32'(bits), 32'(exp));
        chk({tag, " busy"},   nbusy, nbits * div_of(sel));
        chk({tag, " stable"}, 32'(stable), 32'd1);
        chk({tag, " idle"},   {30'd0, tx[sel], bsy[sel]}, 32'b10);
    endtask

    initial begin
        logic [0:15] bits;
        int          nb;
        bit          st;
        int          cnt;

        vecs[0] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0, 11, 16'b0101_0010_1010_0000};
        vecs[1] = '{0, 8'h01, 1'b1, 1'b1, 1'b0, 11, 16'b0100_0000_0010_0000};
        vecs[2] = '{0, 8'h03, 1'b1, 1'b1, 1'b0, 11, 16'b0110_0000_0110_0000};
        vecs[3] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, 10, 16'b0101_0101_0100_0000};
        vecs[4] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 12, 16'b0000_0000_0011_0000};
        vecs[5] = '{0, 8'h80, 1'b0, 1'b0, 1'b1, 11, 16'b0000_0000_1110_0000};
        vecs[6] = '{0, 8'h0F, 1'b1, 1'b0, 1'b1, 12, 16'b0111_1000_0011_0000};
        vecs[7] = '{0, 8'h07, 1'b1, 1'b0, 1'b0, 11, 16'b0111_0000_0110_0000};
        vecs[8] = '{1, 8'hFF, 1'b0, 1'b0, 1'b1, 11, 16'b0111_1111_1110_0000};

        // Reset
        #2 RST = 1'b1;
        #20;
        chk("rst tx0",   32'(tx[0]),  32'd1);
        chk("rst busy0", 32'(bsy[0]), 32'd0);
        chk("rst tx1",   32'(tx[1]),  32'd1);
        chk("rst busy1", 32'(bsy[1]), 32'd0);
        @(negedge CLK) RST = 1'b0;
        @(negedge CLK);
        chk("post-rst idle", {30'd0, tx, bsy}, 32'b1100);

        // Frame table
        for (int i = 0; i < 9; i++) begin
            start(vecs[i].sel, vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].s2);
            capture(vecs[i].sel, 1'b0, -1, bits, nb, st);
            check_frame($sformatf("vec%0d", i), vecs[i].sel, bits, nb, st,
                        vecs[i].exp, vecs[i].nbits);
        end

        // Request with different data during a frame: ignored, not queued
        start(0, 8'h55, 1'b0, 1'b0, 1'b0);
        capture(0, 1'b0, 4, bits, nb, st);
        check_frame("midreq", 0, bits, nb, st, 16'b0101_0101_0100_0000, 10);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (bsy[0]) cnt++;
        end
        chk("midreq no 2nd frame", cnt, 0);

        // Data_Valid held high: exactly one idle clock between frames
        start(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        capture(0, 1'b1, -1, bits, nb, st);
        check_frame("b2b f1", 0, bits, nb, st, 16'b0101_0010_1100_0000, 10);
        @(posedge CLK);
        capture(0, 1'b0, -1, bits, nb, st);
        check_frame("b2b f2", 0, bits, nb, st, 16'b0101_0010_1100_0000, 10);

        // Reset during data bit 3, then a clean frame
        start(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        @(negedge CLK) dv[0] = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("pre-rst bit3", {30'd0, tx[0], bsy[0]}, 32'b01);
        RST = 1'b1;
        #1;
        chk("async rst", {30'd0, tx[0], bsy[0]}, 32'b10);
        @(negedge CLK) RST = 1'b0;
        start(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        capture(0, 1'b0, -1, bits, nb, st);
        check_frame("after rst", 0, bits, nb, st, 16'b0101_0010_1010_0000, 11);

`ifdef UART_TX_FRAME_BREAK_EN
        // Break for 20 clocks on the BAUD_DIV=4 framer, request ignored
        @(negedge CLK);
        brk[1] = 1'b1; dv[1] = 1'b1; pd[1] = 8'h3C;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (tx[1] == 1'b0 && bsy[1] == 1'b1) cnt++;
        end
        brk[1] = 1'b0; dv[1] = 1'b0;
        chk("break low clks", cnt, 20);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (!bsy[1]) break;
            if (tx[1]) cnt++;
        end
        chk("mark clks", cnt, 4);
        chk("break idle", {30'd0, tx[1], bsy[1]}, 32'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
